// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the branch resolve unit: FSM state encoding,
// comparator condition codes and the default link/fall-through offset.
package branch_resolve_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_RESP = 2'd2
  } bru_state_e;

  localparam logic [3:0] OP_EQ  = 4'b0000;
  localparam logic [3:0] OP_LT  = 4'b1001;
  localparam logic [3:0] OP_LEZ = 4'b0010;
  localparam logic [3:0] OP_GTZ = 4'b0011;
  localparam logic [3:0] OP_LTZ = 4'b0100;
  localparam logic [3:0] OP_GEZ = 4'b0101;

  localparam int unsigned LINK_OFS_DFLT = 4;

endpackage

// File: rtl/branch_resolve_unit_target_calc.sv
// Combinational next-PC datapath: fall-through PC (also the link value) and
// the taken target pc + LINK_OFS + (imm << 2), wrapping modulo 2^AW.
module branch_target_calc
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned LINK_OFS = LINK_OFS_DFLT
) (
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] imm,
  input  logic          taken,
  output logic [AW-1:0] next_pc,
  output logic [AW-1:0] fall_pc
);

  always_comb begin
    fall_pc = pc + AW'(LINK_OFS);
    next_pc = taken ? (fall_pc + (imm << 2)) : fall_pc;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: latches one branch request, evaluates it through the
// shared comparator for one cycle, then offers the redirect until accepted.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned LINK_OFS = LINK_OFS_DFLT,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AW-1:0]    req_pc,
  input  logic [AW-1:0]    req_imm,
  input  logic [DW-1:0]    req_a,
  input  logic [DW-1:0]    req_b,
  input  logic [3:0]       req_op,
  input  logic             req_usigned,
  input  logic             req_neg,
  input  logic             req_link,
  output logic [DW-1:0]    cmp_a,
  output logic [DW-1:0]    cmp_b,
  output logic [3:0]       cmp_op,
  output logic             cmp_usigned,
  input  logic             cmp_taken,
  output logic             redir_valid,
  input  logic             redir_ready,
  output logic [AW-1:0]    redir_pc,
  output logic             redir_taken,
  output logic             link_we,
  output logic [AW-1:0]    link_data,
  output logic [CNT_W-1:0] taken_cnt
);

  bru_state_e    state;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] imm_q;
  logic          neg_q;
  logic          link_q;
  logic          taken_now;
  logic          handshake;
  logic [AW-1:0] next_pc;
  logic [AW-1:0] fall_pc;

  assign taken_now = cmp_taken ^ neg_q;
  assign handshake = redir_valid & redir_ready;
  // Link strobe must land in the handshake cycle itself, so it cannot be registered.
  assign link_we   = handshake & link_q;

  branch_target_calc #(
    .AW      (AW),
    .LINK_OFS(LINK_OFS)
  ) u_target_calc (
    .pc     (pc_q),
    .imm    (imm_q),
    .taken  (taken_now),
    .next_pc(next_pc),
    .fall_pc(fall_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      req_ready   <= 1'b1;
      pc_q        <= '0;
      imm_q       <= '0;
      neg_q       <= 1'b0;
      link_q      <= 1'b0;
      cmp_a       <= '0;
      cmp_b       <= '0;
      cmp_op      <= '0;
      cmp_usigned <= 1'b0;
      redir_valid <= 1'b0;
      redir_pc    <= '0;
      redir_taken <= 1'b0;
      link_data   <= '0;
      taken_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            pc_q        <= req_pc;
            imm_q       <= req_imm;
            neg_q       <= req_neg;
            link_q      <= req_link;
            cmp_a       <= req_a;
            cmp_b       <= req_b;
            cmp_op      <= req_op;
            cmp_usigned <= req_usigned;
            req_ready   <= 1'b0;
            state       <= S_EVAL;
          end
        end
        S_EVAL: begin
          redir_taken <= taken_now;
          redir_pc    <= next_pc;
          link_data   <= fall_pc;
          redir_valid <= 1'b1;
          state       <= S_RESP;
        end
        S_RESP: begin
          if (handshake) begin
            if (redir_taken && (taken_cnt != '1)) begin
              taken_cnt <= taken_cnt + CNT_W'(1);
            end
            redir_valid <= 1'b0;
            req_ready   <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: begin
          redir_valid <= 1'b0;
          req_ready   <= 1'b1;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule
